// File: rtl/bf16_norm_pack.sv
// rtl/bf16_norm_pack.sv - BF16 multiplier back end: normalise, round, range-check and pack
module bf16_norm_pack #(
   parameter int MANT_W = 8,
   parameter int EXP_W  = 10,
   parameter bit RND_EN = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_sign,
   input  logic [EXP_W-1:0]    in_exp,
   input  logic [2*MANT_W-1:0] in_mant,
   input  logic                in_zero,
   input  logic                in_inf,
   input  logic                in_nan,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [MANT_W+7:0]   out_result,
   output logic                out_ovf,
   output logic                out_unf
);

   localparam int PROD_W = 2 * MANT_W;
   localparam int FRAC_W = MANT_W - 1;
   localparam int E_W    = EXP_W + 1;

   localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
   localparam logic signed [E_W-1:0] E_ZERO = '0;
   localparam logic signed [E_W-1:0] E_MAX  = E_W'(255);

   // Result class decided in stage 1; specials already resolved by priority
   typedef enum logic [2:0] {
      CLS_NORM = 3'd0,
      CLS_UNF  = 3'd1,
      CLS_ZERO = 3'd2,
      CLS_INF  = 3'd3,
      CLS_NAN  = 3'd4
   } cls_t;

   // ---------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------
   logic s1_valid;
   logic s2_valid;
   logic s1_adv;

   // Stage 2 is the output register, so it can take new data when empty or draining
   assign s1_adv    = !s2_valid | out_ready;
   assign in_ready  = !s1_valid | s1_adv;
   assign out_valid = s2_valid;

   // ---------------------------------------------------------------
   // Stage 1: normalise
   // ---------------------------------------------------------------
   logic                    n_sign;
   logic signed [E_W-1:0]   n_exp;
   logic signed [E_W-1:0]   e_ext;
   logic [FRAC_W-1:0]       n_frac;
   logic                    n_g;
   logic                    n_s;
   cls_t                    n_cls;

   logic                    s1_sign;
   logic signed [E_W-1:0]   s1_exp;
   logic [FRAC_W-1:0]       s1_frac;
   logic                    s1_g;
   logic                    s1_s;
   cls_t                    s1_cls;

   assign e_ext = {in_exp[EXP_W-1], in_exp};

   // Pick the significand window from the leading one and classify specials
   always_comb begin
      n_sign = in_sign;
      n_exp  = e_ext;
      n_frac = '0;
      n_g    = 1'b0;
      n_s    = 1'b0;
      n_cls  = CLS_NORM;
      if (in_mant[PROD_W-1]) begin
         n_frac = in_mant[PROD_W-2 -: FRAC_W];
         n_g    = in_mant[MANT_W-1];
         n_s    = |in_mant[MANT_W-2:0];
         n_exp  = e_ext + E_ONE;
      end else if (in_mant[PROD_W-2]) begin
         n_frac = in_mant[PROD_W-3 -: FRAC_W];
         n_g    = in_mant[MANT_W-2];
         n_s    = |in_mant[MANT_W-3:0];
      end else begin
         // product below 1.0 can only come from an out-of-range approximation
         n_cls  = CLS_UNF;
      end
      if (in_nan | (in_inf & in_zero)) begin
         n_cls = CLS_NAN;
      end else if (in_inf) begin
         n_cls = CLS_INF;
      end else if (in_zero) begin
         n_cls = CLS_ZERO;
      end
   end

   // Stage 1 register: fills when accepting, drains when stage 2 takes it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_exp   <= '0;
         s1_frac  <= '0;
         s1_g     <= 1'b0;
         s1_s     <= 1'b0;
         s1_cls   <= CLS_NORM;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sign <= n_sign;
            s1_exp  <= n_exp;
            s1_frac <= n_frac;
            s1_g    <= n_g;
            s1_s    <= n_s;
            s1_cls  <= n_cls;
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: round, range check, pack
   // ---------------------------------------------------------------
   logic                    rnd;
   logic                    carry;
   logic [FRAC_W-1:0]       frac_r;
   logic signed [E_W-1:0]   exp_r;
   logic [MANT_W+7:0]       n_result;
   logic                    n_ovf;
   logic                    n_unf;

   // Round-to-nearest-even; a carry out of the fraction wraps it to zero and bumps the exponent
   always_comb begin
      rnd             = RND_EN & s1_g & (s1_s | s1_frac[0]);
      {carry, frac_r} = {1'b0, s1_frac} + {{FRAC_W{1'b0}}, rnd};
      exp_r           = s1_exp + {{(E_W-1){1'b0}}, carry};
   end

   // Select packed word and flags; specials never raise ovf/unf
   always_comb begin
      n_result = {s1_sign, 8'h00, {FRAC_W{1'b0}}};
      n_ovf    = 1'b0;
      n_unf    = 1'b0;
      case (s1_cls)
         CLS_NAN:  n_result = {1'b0, 8'hFF, 1'b1, {(FRAC_W-1){1'b0}}};
         CLS_INF:  n_result = {s1_sign, 8'hFF, {FRAC_W{1'b0}}};
         CLS_ZERO: n_result = {s1_sign, 8'h00, {FRAC_W{1'b0}}};
         CLS_UNF: begin
            n_result = {s1_sign, 8'h00, {FRAC_W{1'b0}}};
            n_unf    = 1'b1;
         end
         default: begin
            if (exp_r >= E_MAX) begin
               n_result = {s1_sign, 8'hFF, {FRAC_W{1'b0}}};
               n_ovf    = 1'b1;
            end else if (exp_r <= E_ZERO) begin
               n_result = {s1_sign, 8'h00, {FRAC_W{1'b0}}};
               n_unf    = 1'b1;
            end else begin
               n_result = {s1_sign, exp_r[7:0], frac_r};
            end
         end
      endcase
   end

   // Output register: holds while stalled, reloads when downstream drains it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid   <= 1'b0;
         out_result <= '0;
         out_ovf    <= 1'b0;
         out_unf    <= 1'b0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= n_result;
            out_ovf    <= n_ovf;
            out_unf    <= n_unf;
         end
      end
   end

endmodule

// File: tb/tb_bf16_norm_pack.sv
// tb/tb_bf16_norm_pack.sv - randomized and directed bench for bf16_norm_pack
module tb_bf16_norm_pack;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_sign;
   logic [9:0]  in_exp;
   logic [15:0] in_mant;
   logic        in_zero;
   logic        in_inf;
   logic        in_nan;
   logic        out_ready;

   logic        in_ready, out_valid, out_ovf, out_unf;
   logic [15:0] out_result;
   logic        t_in_ready, t_out_valid, t_out_ovf, t_out_unf;
   logic [15:0] t_out_result;

   always #5 clk = ~clk;

   bf16_norm_pack #(.MANT_W(8), .EXP_W(10), .RND_EN(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_ovf(out_ovf), .out_unf(out_unf)
   );

   bf16_norm_pack #(.MANT_W(8), .EXP_W(10), .RND_EN(1'b0)) u_dut_trunc (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(t_in_ready),
      .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
      .in_zero(in_zero), .in_inf(in_inf), .in_nan(in_nan),
      .out_valid(t_out_valid), .out_ready(out_ready),
      .out_result(t_out_result), .out_ovf(t_out_ovf), .out_unf(t_out_unf)
   );

   typedef struct {
      bit sign;
      int e;
      int mant;
      bit z;
      bit i;
      bit n;
   } op_t;

   int          n_vec = 0;
   int          n_err = 0;
   op_t         pend[$];
   logic [35:0] sb[$];
   bit          stall_prev = 1'b0;
   logic [17:0] held = '0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Value-level reference: integer significand, shift, round on remainder, then range rules
   function automatic logic [17:0] ref_model(bit sign, int e, int mant, bit zero, bit inf, bit nan, bit rnd);
      int          shift, q, rem, half;
      logic [31:0] eb, qb;
      if (nan || (inf && zero)) return {2'b00, 16'h7FC0};
      if (inf)  return {2'b00, sign, 8'hFF, 7'h00};
      if (zero) return {2'b00, sign, 15'h0000};
      if (mant >= 32768) begin
         shift = 8;
         e = e + 1;
      end else if (mant >= 16384) begin
         shift = 7;
      end else begin
         return {2'b01, sign, 15'h0000};
      end
      q    = mant >> shift;
      rem  = mant % (1 << shift);
      half = 1 << (shift - 1);
      if (rnd && (rem > half || (rem == half && (q % 2) == 1))) q = q + 1;
      if (q == 256) begin
         q = 128;
         e = e + 1;
      end
      if (e >= 255) return {2'b10, sign, 8'hFF, 7'h00};
      if (e <= 0)   return {2'b01, sign, 15'h0000};
      eb = e;
      qb = q;
      return {2'b00, sign, eb[7:0], qb[6:0]};
   endfunction

   function automatic op_t mk(bit sign, int e, int mant, bit z, bit i, bit n);
      op_t o;
      o.sign = sign; o.e = e; o.mant = mant; o.z = z; o.i = i; o.n = n;
      return o;
   endfunction

   function automatic op_t rand_op();
      op_t o;
      int  r;
      o.sign = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
         o.e = int'($urandom_range(0, 3)) - 1 + (($urandom_range(0, 1) == 1) ? 0 : 254);
      else
         o.e = int'($urandom_range(0, 540)) - 140;
      r = int'($urandom_range(0, 9));
      if (r < 4)      o.mant = 32768 | int'($urandom_range(0, 32767));
      else if (r < 9) o.mant = 16384 | int'($urandom_range(0, 16383));
      else            o.mant = int'($urandom_range(0, 16383));
      o.z = ($urandom_range(0, 15) == 0);
      o.i = ($urandom_range(0, 15) == 0);
      o.n = ($urandom_range(0, 15) == 0);
      return o;
   endfunction

   // Called at a falling edge after inputs settle: judge what the coming rising edge transfers
   task automatic monitor(output bit acc);
      logic [35:0] e;
      logic [31:0] exp_rdy;
      exp_rdy = (sb.size() == 2 && !out_ready) ? 32'd0 : 32'd1;
      check("in_ready", in_ready, exp_rdy);
      check("t_in_ready", t_in_ready, exp_rdy);
      if (stall_prev) check("hold", {out_ovf, out_unf, out_result}, held);
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_out", out_valid, 0);
         end else begin
            e = sb.pop_front();
            check("result", out_result, e[33:18]);
            check("flags", {out_ovf, out_unf}, e[35:34]);
            check("t_valid", t_out_valid, 1);
            check("t_result", t_out_result, e[15:0]);
            check("t_flags", {t_out_ovf, t_out_unf}, e[17:16]);
         end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_ovf, out_unf, out_result};
      acc        = in_valid && in_ready;
      if (acc)
         sb.push_back({ref_model(in_sign, $signed(in_exp), int'(in_mant), in_zero, in_inf, in_nan, 1'b1),
                        ref_model(in_sign, $signed(in_exp), int'(in_mant), in_zero, in_inf, in_nan, 1'b0)});
   endtask

   // One clock: present head of pend (or junk with in_valid low), monitor, advance to next falling edge
   task automatic step(input bit v, input bit r);
      bit          acc;
      logic [31:0] eb;
      op_t         o;
      if (v && pend.size() > 0) begin
         o = pend[0];
         in_valid = 1'b1;
      end else begin
         o = rand_op();
         in_valid = 1'b0;
      end
      eb        = o.e;
      in_sign   = o.sign;
      in_exp    = eb[9:0];
      in_mant   = o.mant[15:0];
      in_zero   = o.z;
      in_inf    = o.i;
      in_nan    = o.n;
      out_ready = r;
      #1;
      monitor(acc);
      if (acc) void'(pend.pop_front());
      @(negedge clk);
   endtask

   // mode 0: full throughput, 1: random valid/ready, 2: out_ready low for the first 3 cycles
   task automatic run(input int mode);
      int c;
      bit v, r;
      c = 0;
      while ((pend.size() > 0 || sb.size() > 0) && c < 3000) begin
         case (mode)
            0: begin v = 1'b1; r = 1'b1; end
            1: begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 9) < 7); end
            default: begin v = 1'b1; r = (c >= 3); end
         endcase
         if (mode == 2 && c == 2) check("bp_in_ready_full", in_ready, 0);
         step(v, r);
         c++;
      end
      check("drain", pend.size() + sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0;
      in_zero = 1'b0; in_inf = 1'b0; in_nan = 1'b0; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_result", out_result, 16'h0000);
      check("rst_flags", {out_ovf, out_unf}, 2'b00);
      rst_n = 1'b1;
      #1;
      check("rst_in_ready", in_ready, 1);
      @(negedge clk);

      // latency: 1.5 * 1.5
      pend.push_back(mk(0, 127, 'h9000, 0, 0, 0));
      step(1, 1);
      check("lat_edge1", out_valid, 0);
      step(0, 1);
      check("lat_edge2", out_valid, 1);
      check("lat_value", out_result, 16'h4010);
      step(0, 1);

      // directed corners, streamed back to back
      pend.push_back(mk(0, 381, 'h4000, 0, 0, 0));
      pend.push_back(mk(1, 381, 'h4000, 0, 0, 0));
      pend.push_back(mk(1, -125, 'h4000, 0, 0, 0));
      pend.push_back(mk(0, 127, 'h7FC0, 0, 0, 0));
      pend.push_back(mk(0, 127, 'h4040, 0, 0, 0));
      pend.push_back(mk(0, 127, 'h40C0, 0, 0, 0));
      pend.push_back(mk(1, 5, 'h0000, 1, 1, 0));
      pend.push_back(mk(1, 5, 'h4000, 0, 1, 0));
      pend.push_back(mk(1, 5, 'h4000, 1, 0, 0));
      pend.push_back(mk(1, 5, 'h4000, 0, 0, 1));
      pend.push_back(mk(1, 127, 'h2000, 0, 0, 0));
      pend.push_back(mk(0, 254, 'h4000, 0, 0, 0));
      pend.push_back(mk(0, 255, 'h4000, 0, 0, 0));
      pend.push_back(mk(0, 254, 'h8000, 0, 0, 0));
      pend.push_back(mk(0, 254, 'h7FC0, 0, 0, 0));
      pend.push_back(mk(0, 1, 'h4000, 0, 0, 0));
      pend.push_back(mk(0, 0, 'h4000, 0, 0, 0));
      pend.push_back(mk(0, -1, 'hFFFF, 0, 0, 0));
      run(0);

      // backpressure: six ops with the sink stalled for three cycles
      for (int k = 0; k < 6; k++) pend.push_back(rand_op());
      run(2);

      // randomized traffic
      for (int k = 0; k < 400; k++) pend.push_back(rand_op());
      run(1);

      // reset in the middle of a stream
      for (int k = 0; k < 4; k++) pend.push_back(rand_op());
      step(1, 1);
      step(1, 1);
      step(1, 1);
      check("pre_rst_valid", out_valid, 1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_t_out_valid", t_out_valid, 0);
      check("mid_rst_in_ready", in_ready, 1);
      pend.delete();
      sb.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // traffic after reset
      for (int k = 0; k < 20; k++) pend.push_back(rand_op());
      run(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
